// File: rtl/amt_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package amt_pkg;

   localparam logic [2:0] STATUS  = 3'd0;
   localparam logic [2:0] CONTROL = 3'd1;
   localparam logic [2:0] PERIOD  = 3'd2;
   localparam logic [2:0] SNAP    = 3'd3;
   localparam logic [2:0] PRESC   = 3'd4;
   localparam logic [2:0] PENDING = 3'd5;

   localparam int ST_TO  = 0;
   localparam int ST_RUN = 1;

   localparam int CT_ITO   = 0;
   localparam int CT_CONT  = 1;
   localparam int CT_START = 2;
   localparam int CT_STOP  = 3;

endpackage

// File: rtl/amt_channel.sv
// One down-counting interval timer with its own prescaler, period, control and snapshot.
module amt_channel
   import amt_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int COUNT_W      = 32,
   parameter int PRESC_W      = 8,
   parameter int RESET_PERIOD = 49999
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_status,
   input  logic               wr_control,
   input  logic               wr_period,
   input  logic               wr_snap,
   input  logic               wr_presc,
   input  logic [DATA_W-1:0]  writedata,
   output logic [COUNT_W-1:0] period,
   output logic [COUNT_W-1:0] snapshot,
   output logic [PRESC_W-1:0] presc,
   output logic               to,
   output logic               run,
   output logic               ito,
   output logic               cont,
   output logic               irq
);

   logic [COUNT_W-1:0] counter;
   logic [PRESC_W-1:0] presc_cnt;
   logic               tick;
   logic               timeout;
   logic               start;
   logic               stop;

   assign tick    = run && (presc_cnt == presc);
   // A period write force-reloads the counter, which suppresses any coincident timeout.
   assign timeout = tick && (counter == '0) && !wr_period;
   assign start   = wr_control && writedata[CT_START];
   assign stop    = wr_control && writedata[CT_STOP];
   assign irq     = to & ito;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter   <= COUNT_W'(RESET_PERIOD);
         period    <= COUNT_W'(RESET_PERIOD);
         presc_cnt <= '0;
      end else if (wr_period) begin
         counter   <= writedata[COUNT_W-1:0];
         period    <= writedata[COUNT_W-1:0];
         presc_cnt <= '0;
      end else begin
         if (tick) begin
            counter <= (counter == '0) ? period : counter - 1'b1;
         end
         if (run) begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run <= 1'b0;
      end else if (wr_period) begin
         run <= 1'b0;
      end else if (start) begin
         run <= 1'b1;
      end else if (stop) begin
         run <= 1'b0;
      end else if (timeout && !cont) begin
         run <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to <= 1'b0;
      end else if (wr_status) begin
         to <= 1'b0;
      end else if (timeout) begin
         to <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ito      <= 1'b0;
         cont     <= 1'b0;
         presc    <= '0;
         snapshot <= '0;
      end else begin
         if (wr_control) begin
            ito  <= writedata[CT_ITO];
            cont <= writedata[CT_CONT];
         end
         if (wr_presc) begin
            presc <= writedata[PRESC_W-1:0];
         end
         // Captures the value before this cycle's tick is applied.
         if (wr_snap) begin
            snapshot <= counter;
         end
      end
   end

endmodule

// File: rtl/avalon_multi_timer.sv
// Avalon-MM slave with NUM_CH independent interval timers, per-channel and combined IRQ.
module avalon_multi_timer
   import amt_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int DATA_W       = 32,
   parameter int COUNT_W      = 32,
   parameter int PRESC_W      = 8,
   parameter int RESET_PERIOD = 49999
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [$clog2(NUM_CH)+2:0]  address,
   input  logic                       chipselect,
   input  logic                       write_n,
   input  logic [DATA_W-1:0]          writedata,
   output logic [DATA_W-1:0]          readdata,
   output logic                       irq,
   output logic [NUM_CH-1:0]          irq_vec
);

   localparam int ADDR_W = $clog2(NUM_CH) + 3;

   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("NUM_CH must be in 1..8");
   end
   if (COUNT_W > DATA_W || PRESC_W > DATA_W) begin : g_bad_width
      $error("COUNT_W and PRESC_W must not exceed DATA_W");
   end

   logic [ADDR_W-1:0]  ch_sel;
   logic [2:0]         offset;
   logic               wr_en;
   logic [DATA_W-1:0]  rd_next;

   logic [COUNT_W-1:0] period_arr   [NUM_CH];
   logic [COUNT_W-1:0] snapshot_arr [NUM_CH];
   logic [PRESC_W-1:0] presc_arr    [NUM_CH];
   logic [NUM_CH-1:0]  to_vec;
   logic [NUM_CH-1:0]  run_vec;
   logic [NUM_CH-1:0]  ito_vec;
   logic [NUM_CH-1:0]  cont_vec;

   assign ch_sel = address >> 3;
   assign offset = address[2:0];
   assign wr_en  = chipselect & ~write_n;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic hit;
      assign hit = wr_en && (ch_sel == ADDR_W'(i));

      amt_channel #(
         .DATA_W       (DATA_W),
         .COUNT_W      (COUNT_W),
         .PRESC_W      (PRESC_W),
         .RESET_PERIOD (RESET_PERIOD)
      ) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .wr_status  (hit && (offset == STATUS)),
         .wr_control (hit && (offset == CONTROL)),
         .wr_period  (hit && (offset == PERIOD)),
         .wr_snap    (hit && (offset == SNAP)),
         .wr_presc   (hit && (offset == PRESC)),
         .writedata  (writedata),
         .period     (period_arr[i]),
         .snapshot   (snapshot_arr[i]),
         .presc      (presc_arr[i]),
         .to         (to_vec[i]),
         .run        (run_vec[i]),
         .ito        (ito_vec[i]),
         .cont       (cont_vec[i]),
         .irq        (irq_vec[i])
      );
   end

   assign irq = |irq_vec;

   // Channel indices with no channel behind them fall through to zero.
   always_comb begin
      rd_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == ADDR_W'(i)) begin
            case (offset)
               STATUS:  rd_next = DATA_W'({run_vec[i], to_vec[i]});
               CONTROL: rd_next = DATA_W'({cont_vec[i], ito_vec[i]});
               PERIOD:  rd_next = DATA_W'(period_arr[i]);
               SNAP:    rd_next = DATA_W'(snapshot_arr[i]);
               PRESC:   rd_next = DATA_W'(presc_arr[i]);
               PENDING: rd_next = DATA_W'(to_vec);
               default: rd_next = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_next;
      end
   end

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Bench for avalon_multi_timer: reference-model monitor, vector table, directed timing sequences, random traffic.
`timescale 1ns/1ps
module tb_avalon_multi_timer;
   import amt_pkg::*;

   localparam int NUM_CH = 4;
   localparam int AW     = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic          irq;
   logic [NUM_CH-1:0] irq_vec;

   avalon_multi_timer #(
      .NUM_CH(NUM_CH), .DATA_W(32), .COUNT_W(32), .PRESC_W(8), .RESET_PERIOD(49999)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq(irq), .irq_vec(irq_vec)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   bit          mon_en  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: each channel's state as plain numbers, advanced once per clock
   logic [31:0] m_cnt [NUM_CH];
   logic [31:0] m_per [NUM_CH];
   logic [31:0] m_snap[NUM_CH];
   int          m_pc  [NUM_CH];
   int          m_ps  [NUM_CH];
   bit          m_run [NUM_CH];
   bit          m_to  [NUM_CH];
   bit          m_ito [NUM_CH];
   bit          m_cont[NUM_CH];
   logic [31:0] m_rd;

   always @(posedge clk or negedge reset_n) begin
      bit          we, hit, pw, tk, tmo;
      int          ch, off;
      logic [31:0] wd, rdv, pend;
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 49999; m_per[i] = 49999; m_snap[i] = 0;
            m_pc[i] = 0; m_ps[i] = 0;
            m_run[i] = 0; m_to[i] = 0; m_ito[i] = 0; m_cont[i] = 0;
         end
         m_rd = 0;
      end else begin
         we  = chipselect && !write_n;
         ch  = int'(address) / 8;
         off = int'(address) % 8;
         wd  = writedata;
         pend = 0;
         for (int i = 0; i < NUM_CH; i++) pend[i] = m_to[i];
         rdv = 0;
         if (ch < NUM_CH) begin
            case (off)
               0: rdv = {30'd0, m_run[ch], m_to[ch]};
               1: rdv = {30'd0, m_cont[ch], m_ito[ch]};
               2: rdv = m_per[ch];
               3: rdv = m_snap[ch];
               4: rdv = 32'(m_ps[ch]);
               5: rdv = pend;
               default: rdv = 0;
            endcase
         end
         for (int i = 0; i < NUM_CH; i++) begin
            hit = we && (ch == i);
            pw  = hit && (off == 2);
            tk  = m_run[i] && (m_pc[i] == m_ps[i]);
            tmo = tk && (m_cnt[i] == 0) && !pw;
            if (hit && off == 3) m_snap[i] = m_cnt[i];
            if (pw) begin
               m_per[i] = wd; m_cnt[i] = wd; m_pc[i] = 0; m_run[i] = 0;
            end else begin
               if (tk) m_cnt[i] = (m_cnt[i] == 0) ? m_per[i] : m_cnt[i] - 1;
               if (m_run[i]) m_pc[i] = tk ? 0 : (m_pc[i] + 1) % 256;
               if (hit && off == 1 && wd[2])      m_run[i] = 1;
               else if (hit && off == 1 && wd[3]) m_run[i] = 0;
               else if (tmo && !m_cont[i])        m_run[i] = 0;
            end
            if (hit && off == 0) m_to[i] = 0;
            else if (tmo)        m_to[i] = 1;
            if (hit && off == 1) begin m_ito[i] = wd[0]; m_cont[i] = wd[1]; end
            if (hit && off == 4) m_ps[i] = int'(wd % 256);
         end
         m_rd = rdv;
      end
   end

   always @(negedge clk) begin
      logic [NUM_CH-1:0] exp_vec;
      if (mon_en) begin
         for (int i = 0; i < NUM_CH; i++) exp_vec[i] = m_to[i] & m_ito[i];
         chk("mon_readdata", readdata, m_rd);
         chk("mon_irq_vec", 32'(irq_vec), 32'(exp_vec));
         chk("mon_irq", 32'(irq), 32'(|exp_vec));
      end
   end

   task automatic bus_wr(input int ch, input int off, input logic [31:0] d);
      @(negedge clk);
      address = AW'(ch * 8 + off); chipselect = 1; write_n = 0; writedata = d;
      @(negedge clk);
      chipselect = 0; write_n = 1;
   endtask

   task automatic bus_rd(input int ch, input int off, output logic [31:0] d);
      @(negedge clk);
      address = AW'(ch * 8 + off); chipselect = 1; write_n = 1;
      @(negedge clk);
      d = readdata; chipselect = 0;
   endtask

   task automatic wait_irq(input int ch, input int max, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!irq_vec[ch] && n < max);
      if (!irq_vec[ch]) begin
         n_tests++; n_fail++;
         $display("FAIL wait_irq_ch%0d: irq_vec not seen within %0d clks", ch, max);
      end
   endtask

   typedef struct {
      bit          do_wr;
      int          ch;
      int          off;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[17];

   initial begin
      logic [31:0] d, d1;
      int          n;
      int unsigned s, t1, t2, w;

      vecs[0]  = '{0, 0, PERIOD,  32'h0,        32'd49999};
      vecs[1]  = '{0, 0, STATUS,  32'h0,        32'h0};
      vecs[2]  = '{0, 2, CONTROL, 32'h0,        32'h0};
      vecs[3]  = '{0, 3, SNAP,    32'h0,        32'h0};
      vecs[4]  = '{0, 1, PRESC,   32'h0,        32'h0};
      vecs[5]  = '{0, 2, PENDING, 32'h0,        32'h0};
      vecs[6]  = '{0, 0, 6,       32'h0,        32'h0};
      vecs[7]  = '{0, 1, 7,       32'h0,        32'h0};
      vecs[8]  = '{1, 0, PRESC,   32'h1AB,      32'hAB};
      vecs[9]  = '{1, 0, PRESC,   32'h0,        32'h0};
      vecs[10] = '{1, 3, CONTROL, 32'h3,        32'h3};
      vecs[11] = '{1, 3, CONTROL, 32'h0,        32'h0};
      vecs[12] = '{1, 2, 6,       32'hFFFFFFFF, 32'h0};
      vecs[13] = '{1, 1, PENDING, 32'hF,        32'h0};
      vecs[14] = '{1, 2, SNAP,    32'h1234,     32'd49999};
      vecs[15] = '{1, 3, PERIOD,  32'h12345678, 32'h12345678};
      vecs[16] = '{1, 3, STATUS,  32'hFF,       32'h0};

      address = '0; chipselect = 0; write_n = 1; writedata = '0; reset_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_readdata", readdata, 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_irq_vec", 32'(irq_vec), 0);
      #2 reset_n = 1;
      @(negedge clk);
      mon_en = 1;

      for (int i = 0; i < 17; i++) begin
         if (vecs[i].do_wr) bus_wr(vecs[i].ch, vecs[i].off, vecs[i].wd);
         bus_rd(vecs[i].ch, vecs[i].off, d);
         chk($sformatf("vec%0d", i), d, vecs[i].exp);
      end

      // ch1 free-running every 10 clks
      bus_wr(1, PERIOD, 9);
      bus_wr(1, PRESC, 0);
      bus_wr(1, CONTROL, 7);
      chk("ch1_no_irq_at_start", 32'(irq_vec[1]), 0);
      wait_irq(1, 40, n);
      chk("ch1_first_timeout_clks", n, 10);
      t1 = cyc;
      bus_wr(1, STATUS, 0);
      chk("ch1_status_clear", 32'(irq_vec[1]), 0);
      wait_irq(1, 40, n);
      t2 = cyc;
      chk("ch1_interval2", t2 - t1, 10);
      bus_wr(1, STATUS, 0);
      wait_irq(1, 40, n);
      chk("ch1_interval3", cyc - t2, 10);
      bus_wr(1, CONTROL, 8);
      bus_wr(1, STATUS, 0);

      // ch2 one-shot with prescaler
      bus_wr(2, PERIOD, 3);
      bus_wr(2, PRESC, 4);
      bus_wr(2, CONTROL, 5);
      wait_irq(2, 60, n);
      chk("ch2_oneshot_clks", n, 20);
      repeat (10) @(negedge clk);
      bus_rd(2, STATUS, d);
      chk("ch2_status_to_stopped", d, 1);
      bus_wr(2, SNAP, 0);
      bus_rd(2, SNAP, d);
      chk("ch2_counter_holds", d, 3);
      bus_rd(0, PENDING, d);
      chk("pending_at_ch0", d, 4);
      bus_rd(3, PENDING, d);
      chk("pending_at_ch3", d, 4);
      chk("ch2_irq", 32'(irq), 1);
      bus_wr(2, STATUS, 0);
      bus_wr(2, CONTROL, 0);

      // ch0 period write while running
      bus_wr(0, CONTROL, 6);
      repeat (5) @(negedge clk);
      bus_wr(0, PERIOD, 100);
      bus_rd(0, STATUS, d);
      chk("ch0_period_wr_stops", d, 0);
      bus_wr(0, SNAP, 0);
      bus_rd(0, SNAP, d);
      chk("ch0_period_reload", d, 100);
      bus_wr(0, CONTROL, 32'hE);
      bus_rd(0, STATUS, d);
      chk("ch0_start_beats_stop", d, 2);
      bus_wr(0, CONTROL, 8);

      // ch3 snapshot of a running counter
      bus_wr(3, PERIOD, 1000);
      bus_wr(3, PRESC, 0);
      bus_wr(3, CONTROL, 6);
      s = cyc;
      repeat (7) @(negedge clk);
      bus_wr(3, SNAP, 0);
      w = cyc;
      bus_rd(3, SNAP, d);
      chk("ch3_snap_value", d, 1000 - (w - s - 1));
      repeat (3) @(negedge clk);
      bus_rd(3, SNAP, d1);
      chk("ch3_snap_stable", d1, 1000 - (w - s - 1));

      // status clear landing on the timeout edge
      bus_wr(1, PERIOD, 9);
      bus_wr(1, CONTROL, 7);
      s = cyc;
      for (int k = 0; k < 20 && cyc != s + 8; k++) @(negedge clk);
      bus_wr(1, STATUS, 0);
      chk("coincident_clear_irq_vec", 32'(irq_vec[1]), 0);
      chk("coincident_clear_irq", 32'(irq), 0);
      bus_rd(1, STATUS, d);
      chk("coincident_clear_status", d, 2);

      // reset in the middle of counting
      wait_irq(1, 40, n);
      chk("pre_reset_irq", 32'(irq), 1);
      @(negedge clk);
      #2 reset_n = 0;
      #1;
      chk("reset_async_irq", 32'(irq), 0);
      chk("reset_async_irq_vec", 32'(irq_vec), 0);
      chk("reset_async_readdata", readdata, 0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("post_reset_irq", 32'(irq), 0);
      end
      bus_rd(0, PERIOD, d);
      chk("post_reset_ch0_period", d, 49999);
      bus_rd(1, PERIOD, d);
      chk("post_reset_ch1_period", d, 49999);
      bus_rd(1, STATUS, d);
      chk("post_reset_ch1_status", d, 0);
      bus_rd(3, CONTROL, d);
      chk("post_reset_ch3_control", d, 0);
      bus_rd(3, SNAP, d);
      chk("post_reset_ch3_snap", d, 0);

      // random traffic, checked by the model monitor
      for (int k = 0; k < 3000; k++) begin
         int r, ch, off;
         logic [31:0] dat;
         @(negedge clk);
         r   = $urandom_range(0, 9);
         ch  = $urandom_range(0, NUM_CH - 1);
         off = $urandom_range(0, 7);
         dat = $urandom;
         if (off == 2) dat = dat & 32'h1F;
         if (off == 4 && $urandom_range(0, 7) != 0) dat = dat & 32'h3;
         address    = AW'(ch * 8 + off);
         writedata  = dat;
         chipselect = (r < 7);
         write_n    = !(r < 3 || r == 9);
      end
      @(negedge clk);
      chipselect = 0; write_n = 1;
      repeat (5) @(negedge clk);
      mon_en = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
